// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bin, DIGIT bits per clock with the borrow
// carried between cycles, valid/ready on both sides and a signed-overflow flag.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]         digit_diff;
    logic [WIDTH+DIGIT-1:0] r_wide;
    logic [WIDTH-1:0]       r_shifted;

    // One digit of subtraction; the extra top bit of digit_diff is the new borrow.
    always_comb begin
        digit_diff = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};
        r_wide     = {digit_diff[DIGIT-1:0], r_sh_q};
        r_shifted  = r_wide[WIDTH+DIGIT-1:DIGIT];
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                r_sh_d   = r_shifted;
                borrow_d = digit_diff[DIGIT];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    d_d     = r_shifted;
                    bout_d  = digit_diff[DIGIT];
                    // Overflow only possible when operand signs differ.
                    ovf_d   = (a_msb_q != b_msb_q) && (r_shifted[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor computing d = a - b - bin on WIDTH-bit operands, DIGIT bits per clock, with borrow carried between cycles. It is the sequential successor of the team's single-bit gate-level full subtractor, generalised in operand width and digit size, and adds a valid/ready handshake and a signed-overflow flag. It sits between a producer and a consumer stream and trades area for latency.

Parameters:
WIDTH, 8, operand and result width in bits (>=1).
DIGIT, 1, bits processed per clock; WIDTH % DIGIT must be 0, otherwise elaboration fails.
(derived) STEPS = WIDTH/DIGIT, number of RUN cycles.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
d  output  WIDTH  difference
bout  output  1  borrow-out (1 when a < b + bin, unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous): state=IDLE; all internal registers, d, bout, ovf=0; out_valid=0; in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. Edge with in_valid=1: latch a, b into shift registers, borrow reg=bin, step count=0, sign bits a[WIDTH-1], b[WIDTH-1] saved -> RUN.
- RUN: in_ready=0. Each edge: low DIGIT bits of a/b regs minus borrow reg -> DIGIT result bits plus new borrow; a/b regs shift right by DIGIT; result bits shift in at top of result shift reg; count++. On the edge where count==STEPS-1: load d, bout, ovf output registers from final values -> DONE.
- Latency: out_valid rises exactly STEPS edges after the accepting edge (WIDTH=8, DIGIT=1: 8; DIGIT=4: 2; DIGIT=WIDTH: 1).
- DONE: out_valid=1, in_ready=0; d/bout/ovf stable until out_valid&&out_ready edge -> IDLE. No accept in the same cycle as result handoff; in_ready rises the cycle after handoff.
- ovf = (a_msb != b_msb) && (d_msb != a_msb); bin is included in d before this evaluation.
- d, bout, ovf are registered and hold the last result in IDLE and RUN until the next completion overwrites them; they are meaningful only while out_valid=1.
- in_valid while not IDLE: ignored, operands not latched, no state change.
- out_ready while not DONE: ignored.
- Arithmetic is modulo 2^WIDTH; bout is the final borrow after the MSB digit.
- rst_n asserted mid-RUN or in DONE: operation aborted, result discarded, outputs return to reset values immediately.
- No combinational path from in_valid/out_ready to any output; in_ready/out_valid are decoded from the state register only.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> d=0x02, bout=0, ovf=0; out_valid high exactly 8 edges after accept.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0; a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
- Borrow-in: a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0; a=0x00, b=0xFF, bin=1 -> d=0x00, bout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid, d, bout, ovf unchanged, in_ready=0, new operands not taken; in_ready=1 the cycle after out_ready handoff.
- Reset mid-RUN (rst_n low after 4 steps) -> out_valid=0, d=0, in_ready=1 while in reset; next op a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
- DIGIT=4 and DIGIT=8 builds: random 1000 vectors vs reference model; latency 2 and 1 respectively; back-to-back ops with out_ready tied 1 give one result per STEPS+2 cycles.
